lcd_rx: RTL and testbench

Receive-side counterpart of the serial-RGB LCD timing generator. It samples the 8-bit, three-bytes-per-pixel LCD bus (`lcd_dat`, `lcd_hsync`, `lcd_vsync`, `lcd_den`) in the pixel-byte clock domain. It reassembles 24-bit pixels, tags them with x/y coordinates, and checks line and frame geometry. It serves as the capture/loopback checker for the video path and as the front end for any future camera-style input.

---
 rtl/lcd_rx.sv | 229 ++++++++++++++++++++++
 tb/tb_lcd_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rx.sv
// lcd_rx -- receive side of the serial-RGB LCD bus.
//
// Samples the three-bytes-per-pixel bus in the byte-clock domain. It rebuilds
// 24-bit pixels and tags each one with its x/y position. It also checks the
// length of every line and the line count of every frame.
//
// Ports:
//   clk          byte clock (the clock that drives the bus)
//   resetn       synchronous, active-low reset
//   lcd_dat      byte stream, R, G, B per pixel
//   lcd_hsync    line sync, active low
//   lcd_vsync    frame sync, active low
//   lcd_den      data enable, active low (low = visible byte)
//   pix_valid    one-cycle strobe; pix_rgb/pix_x/pix_y valid
//   pix_rgb      {R,G,B} of the completed pixel
//   pix_x/pix_y  0-based column / row of the pixel
//   frame_start  one-cycle pulse on vsync assertion
//   line_start   one-cycle pulse on hsync assertion
//   locked       high once a vsync assertion has been seen since reset
//   line_err     one-cycle pulse: bad line length or run ended mid-pixel
//   frame_err    one-cycle pulse: frame had the wrong number of lines
module lcd_rx #(
  parameter int H_VISIBLE = 320,
  parameter int V_VISIBLE = 240
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  lcd_dat,
  input  logic        lcd_hsync,
  input  logic        lcd_vsync,
  input  logic        lcd_den,
  output logic        pix_valid,
  output logic [23:0] pix_rgb,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start,
  output logic        line_start,
  output logic        locked,
  output logic        line_err,
  output logic        frame_err
);

  localparam logic [9:0] H_VIS = H_VISIBLE[9:0];
  localparam logic [9:0] V_VIS = V_VISIBLE[9:0];

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_t;

  // Counters stop at the top of their range; they never wrap.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

  // Input stage (s1) and edge-detect stage (s2).
  logic [7:0] dat_s1_r;
  logic       hsync_s1_r, vsync_s1_r, den_s1_r;
  logic       hsync_s2_r, vsync_s2_r, den_s2_r;

  // Capture state.
  phase_t     phase_r, phase_nxt_s;
  logic [9:0] pix_cnt_r, pix_cnt_nxt_s;
  logic [9:0] line_cnt_r, line_cnt_nxt_s, line_base_s;
  logic       locked_r, locked_nxt_s;
  logic [7:0] r_byte_r, r_byte_nxt_s;
  logic [7:0] g_byte_r, g_byte_nxt_s;
  logic       pix_done_s;

  // Pulse events are staged once before the output register.
  logic fs_evt_r, ls_evt_r, le_evt_r, fe_evt_r;
  logic fs_evt_s, ls_evt_s, le_evt_s, fe_evt_s;

  // Output registers.
  logic        pix_valid_r, pix_valid_nxt_s;
  logic [23:0] pix_rgb_r, pix_rgb_nxt_s;
  logic [9:0]  pix_x_r, pix_x_nxt_s;
  logic [9:0]  pix_y_r, pix_y_nxt_s;
  logic        frame_start_r, line_start_r, line_err_r, frame_err_r;

  logic vs_fall_s, hs_fall_s, run_start_s, run_end_s;

  assign vs_fall_s   = vsync_s2_r & ~vsync_s1_r;
  assign hs_fall_s   = hsync_s2_r & ~hsync_s1_r;
  assign run_start_s = den_s2_r & ~den_s1_r;
  assign run_end_s   = ~den_s2_r & den_s1_r;

  // Next-state logic: byte phase, counters, lock, pixel assembly and events.
  always_comb begin
    phase_nxt_s     = phase_r;
    pix_cnt_nxt_s   = pix_cnt_r;
    line_base_s     = line_cnt_r;
    line_cnt_nxt_s  = line_cnt_r;
    locked_nxt_s    = locked_r;
    r_byte_nxt_s    = r_byte_r;
    g_byte_nxt_s    = g_byte_r;
    pix_done_s      = 1'b0;
    pix_valid_nxt_s = 1'b0;
    pix_rgb_nxt_s   = pix_rgb_r;
    pix_x_nxt_s     = pix_x_r;
    pix_y_nxt_s     = pix_y_r;

    // Phase only moves while den is active; an inactive byte drops any partial pixel.
    if (!den_s1_r) begin
      case (phase_r)
        PH_R: begin
          r_byte_nxt_s = dat_s1_r;
          phase_nxt_s  = PH_G;
        end
        PH_G: begin
          g_byte_nxt_s = dat_s1_r;
          phase_nxt_s  = PH_B;
        end
        PH_B: begin
          pix_done_s  = 1'b1;
          phase_nxt_s = PH_R;
        end
        default: phase_nxt_s = PH_R;
      endcase
    end else begin
      phase_nxt_s = PH_R;
    end

    if (run_start_s) begin
      pix_cnt_nxt_s = 10'd0;
    end else if (pix_done_s) begin
      pix_cnt_nxt_s = sat_inc(pix_cnt_r);
    end else begin
      pix_cnt_nxt_s = pix_cnt_r;
    end

    // Vsync mid-run clears first, so the run's end still counts as line 0.
    if (vs_fall_s) begin
      line_base_s  = 10'd0;
      locked_nxt_s = 1'b1;
    end else begin
      line_base_s  = line_cnt_r;
      locked_nxt_s = locked_r;
    end
    if (run_end_s) begin
      line_cnt_nxt_s = sat_inc(line_base_s);
    end else begin
      line_cnt_nxt_s = line_base_s;
    end

    if (pix_done_s && locked_r) begin
      pix_valid_nxt_s = 1'b1;
      pix_rgb_nxt_s   = {r_byte_r, g_byte_r, dat_s1_r};
      pix_x_nxt_s     = pix_cnt_r;
      pix_y_nxt_s     = line_cnt_r;
    end else begin
      pix_valid_nxt_s = 1'b0;
    end
  end

  assign fs_evt_s = vs_fall_s;
  assign ls_evt_s = hs_fall_s;
  assign le_evt_s = run_end_s & locked_r & ((pix_cnt_r != H_VIS) | (phase_r != PH_R));
  assign fe_evt_s = vs_fall_s & locked_r & (line_cnt_r != V_VIS);

  // All state and output registers, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dat_s1_r      <= 8'h00;
      hsync_s1_r    <= 1'b1;
      vsync_s1_r    <= 1'b1;
      den_s1_r      <= 1'b1;
      hsync_s2_r    <= 1'b1;
      vsync_s2_r    <= 1'b1;
      den_s2_r      <= 1'b1;
      phase_r       <= PH_R;
      pix_cnt_r     <= 10'd0;
      line_cnt_r    <= 10'd0;
      locked_r      <= 1'b0;
      r_byte_r      <= 8'h00;
      g_byte_r      <= 8'h00;
      fs_evt_r      <= 1'b0;
      ls_evt_r      <= 1'b0;
      le_evt_r      <= 1'b0;
      fe_evt_r      <= 1'b0;
      pix_valid_r   <= 1'b0;
      pix_rgb_r     <= 24'h000000;
      pix_x_r       <= 10'd0;
      pix_y_r       <= 10'd0;
      frame_start_r <= 1'b0;
      line_start_r  <= 1'b0;
      line_err_r    <= 1'b0;
      frame_err_r   <= 1'b0;
    end else begin
      dat_s1_r      <= lcd_dat;
      hsync_s1_r    <= lcd_hsync;
      vsync_s1_r    <= lcd_vsync;
      den_s1_r      <= lcd_den;
      hsync_s2_r    <= hsync_s1_r;
      vsync_s2_r    <= vsync_s1_r;
      den_s2_r      <= den_s1_r;
      phase_r       <= phase_nxt_s;
      pix_cnt_r     <= pix_cnt_nxt_s;
      line_cnt_r    <= line_cnt_nxt_s;
      locked_r      <= locked_nxt_s;
      r_byte_r      <= r_byte_nxt_s;
      g_byte_r      <= g_byte_nxt_s;
      fs_evt_r      <= fs_evt_s;
      ls_evt_r      <= ls_evt_s;
      le_evt_r      <= le_evt_s;
      fe_evt_r      <= fe_evt_s;
      pix_valid_r   <= pix_valid_nxt_s;
      pix_rgb_r     <= pix_rgb_nxt_s;
      pix_x_r       <= pix_x_nxt_s;
      pix_y_r       <= pix_y_nxt_s;
      frame_start_r <= fs_evt_r;
      line_start_r  <= ls_evt_r;
      line_err_r    <= le_evt_r;
      frame_err_r   <= fe_evt_r;
    end
  end

  assign pix_valid   = pix_valid_r;
  assign pix_rgb     = pix_rgb_r;
  assign pix_x       = pix_x_r;
  assign pix_y       = pix_y_r;
  assign frame_start = frame_start_r;
  assign line_start  = line_start_r;
  assign locked      = locked_r;
  assign line_err    = line_err_r;
  assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_lcd_rx.sv
// Directed bench for lcd_rx using a reduced 8x4 geometry.
module tb_lcd_rx;

  localparam int H = 8;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  lcd_dat = 8'h00;
  logic        lcd_hsync = 1'b1;
  logic        lcd_vsync = 1'b1;
  logic        lcd_den = 1'b1;
  logic        pix_valid;
  logic [23:0] pix_rgb;
  logic [9:0]  pix_x, pix_y;
  logic        frame_start, line_start, locked, line_err, frame_err;

  lcd_rx #(.H_VISIBLE(H), .V_VISIBLE(V)) dut (
    .clk(clk), .resetn(resetn), .lcd_dat(lcd_dat), .lcd_hsync(lcd_hsync),
    .lcd_vsync(lcd_vsync), .lcd_den(lcd_den), .pix_valid(pix_valid),
    .pix_rgb(pix_rgb), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
    .line_start(line_start), .locked(locked), .line_err(line_err),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected pixels {rgb, x, y} and a small model of sync state.
  logic [43:0] exp_q[$];
  bit m_locked = 1'b0;
  int m_line = 0;
  int n_push = 0, n_drop = 0, n_strobe = 0;
  int le_cnt = 0, fe_cnt = 0, fs_cnt = 0, ls_cnt = 0;
  int exp_le = 0, exp_fe = 0, exp_fs = 0, exp_ls = 0;
  int lat_cyc = 0, den_off_cyc = 0, vs_on_cyc = 0, hs_on_cyc = 0;
  bit lat_pend = 1'b0;

  function automatic logic [23:0] pix_val(input int x, input int y);
    return {x[7:0], y[7:0], 8'hA5};
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (pix_valid) begin
      n_strobe++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        logic [43:0] e;
        e = exp_q.pop_front();
        check_val("pix_rgb", 32'(pix_rgb), 32'(e[43:20]));
        check_val("pix_x", 32'(pix_x), 32'(e[19:10]));
        check_val("pix_y", 32'(pix_y), 32'(e[9:0]));
      end
      if (lat_pend) begin
        check_val("pix_latency", 32'(cyc - lat_cyc), 32'd2);
        lat_pend = 1'b0;
      end
    end
    if (line_err) begin
      le_cnt++;
      check_val("line_err_latency", 32'(cyc - den_off_cyc), 32'd3);
    end
    if (frame_err) begin
      fe_cnt++;
      check_val("frame_err_latency", 32'(cyc - vs_on_cyc), 32'd3);
    end
    if (frame_start) begin
      fs_cnt++;
      check_val("frame_start_latency", 32'(cyc - vs_on_cyc), 32'd3);
    end
    if (line_start) begin
      ls_cnt++;
      check_val("line_start_latency", 32'(cyc - hs_on_cyc), 32'd3);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_valid"}, 32'(pix_valid), 32'd0);
    check_val({tag, "_rgb"}, 32'(pix_rgb), 32'd0);
    check_val({tag, "_x"}, 32'(pix_x), 32'd0);
    check_val({tag, "_y"}, 32'(pix_y), 32'd0);
    check_val({tag, "_locked"}, 32'(locked), 32'd0);
    check_val({tag, "_pulses"}, 32'({frame_start, line_start, line_err, frame_err}), 32'd0);
  endtask

  task automatic do_vsync();
    tick();
    lcd_vsync = 1'b0;
    vs_on_cyc = cyc;
    exp_fs++;
    if (m_locked && m_line != V) exp_fe++;
    m_line = 0;
    m_locked = 1'b1;
    idle(2);
    tick();
    lcd_vsync = 1'b1;
    idle(3);
  endtask

  // One line: hsync, then npix pixels plus 'extra' stray bytes. lat marks
  // pixel 0 as 0x112233 with a latency check; rst_at >= 0 pulses reset at
  // that pixel's R byte.
  task automatic do_line(input int npix, input int extra, input bit lat, input int rst_at);
    tick();
    lcd_hsync = 1'b0;
    hs_on_cyc = cyc;
    exp_ls++;
    idle(2);
    tick();
    lcd_hsync = 1'b1;
    idle(2);
    for (int b = 0; b < npix * 3 + extra; b++) begin
      int x;
      int ph;
      logic [23:0] v;
      x = b / 3;
      ph = b % 3;
      v = (lat && x == 0) ? 24'h112233 : pix_val(x, m_line);
      tick();
      if (rst_at >= 0 && x == rst_at && ph == 0) begin
        resetn = 1'b0;
      end else if (!resetn) begin
        resetn = 1'b1;
        n_drop += exp_q.size();
        exp_q.delete();
        m_locked = 1'b0;
        m_line = 0;
        @(negedge clk);
        check_zero_outputs("after_reset");
        #1;
      end
      lcd_den = 1'b0;
      lcd_dat = (ph == 0) ? v[23:16] : (ph == 1) ? v[15:8] : v[7:0];
      if (ph == 2 && m_locked) begin
        exp_q.push_back({v, 10'(x), 10'(m_line)});
        n_push++;
      end
      if (ph == 2 && lat && x == 0) begin
        lat_cyc = cyc;
        lat_pend = 1'b1;
      end
    end
    tick();
    lcd_den = 1'b1;
    lcd_dat = 8'h00;
    den_off_cyc = cyc;
    if (m_locked && (npix != H || extra != 0)) exp_le++;
    m_line++;
    idle(4);
  endtask

  initial begin
    idle(3);
    @(negedge clk);
    check_zero_outputs("reset");
    tick();
    resetn = 1'b1;
    idle(2);

    // Partial line before any vsync: no strobes, no error.
    do_line(3, 0, 1'b0, -1);
    check_val("unlocked_line_err", 32'(le_cnt), 32'd0);
    check_val("unlocked_strobes", 32'(n_strobe), 32'd0);
    check_val("unlocked_locked", 32'(locked), 32'd0);

    // First vsync locks; the truncated pre-lock frame is not flagged.
    do_vsync();
    check_val("locked_after_vsync", 32'(locked), 32'd1);
    check_val("first_frame_no_err", 32'(fe_cnt), 32'd0);

    // Frame A: nominal, pixel 0 of line 0 carries the latency check.
    do_line(H, 0, 1'b1, -1);
    for (int i = 0; i < 3; i++) do_line(H, 0, 1'b0, -1);
    do_vsync();
    check_val("frame_a_line_err", 32'(le_cnt), 32'd0);
    check_val("frame_a_frame_err", 32'(fe_cnt), 32'd0);
    check_val("frame_a_strobes", 32'(n_strobe), 32'(4 * H));

    // Frame B: short line, nominal, line ending mid-pixel, nominal.
    do_line(H - 1, 0, 1'b0, -1);
    check_val("short_line_err", 32'(le_cnt), 32'd1);
    do_line(H, 0, 1'b0, -1);
    do_line(H, 2, 1'b0, -1);
    check_val("mid_pixel_err", 32'(le_cnt), 32'd2);
    do_line(H, 0, 1'b0, -1);
    do_vsync();
    check_val("frame_b_frame_err", 32'(fe_cnt), 32'd0);

    // Frame C: one line short.
    for (int i = 0; i < 3; i++) do_line(H, 0, 1'b0, -1);
    do_vsync();
    check_val("short_frame_err", 32'(fe_cnt), 32'd1);

    // Frame D: reset mid-line, then nothing until the next vsync.
    do_line(H, 0, 1'b0, -1);
    do_line(H, 0, 1'b0, 3);
    do_line(H, 0, 1'b0, -1);
    check_val("post_reset_locked", 32'(locked), 32'd0);
    check_val("post_reset_line_err", 32'(le_cnt), 32'd2);
    do_vsync();
    check_val("relock_no_frame_err", 32'(fe_cnt), 32'd1);
    for (int i = 0; i < V; i++) do_line(H, 0, 1'b0, -1);
    do_vsync();
    idle(5);

    check_val("total_line_err", 32'(le_cnt), 32'(exp_le));
    check_val("total_frame_err", 32'(fe_cnt), 32'(exp_fe));
    check_val("total_frame_start", 32'(fs_cnt), 32'd6);
    check_val("model_frame_start", 32'(fs_cnt), 32'(exp_fs));
    check_val("total_line_start", 32'(ls_cnt), 32'd19);
    check_val("model_line_start", 32'(ls_cnt), 32'(exp_ls));
    check_val("total_strobes", 32'(n_strobe), 32'(n_push - n_drop));
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    check_val("final_locked", 32'(locked), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
